write_scatter_engine: RTL and testbench

//  Parametrised, handshaked successor of the bit-interleaving write path into the bit-plane memory.

---
 rtl/wsc_pkg.sv | 24 ++
 rtl/write_scatter_engine_if.sv | 52 +++++
 rtl/wsc_slice_scatter.sv | 21 ++
 rtl/write_scatter_engine.sv | 113 +++++++++++
 tb/tb_write_scatter_engine.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/wsc_pkg.sv
// Shared constants for the write scatter engine.
// FSM encoding, clog2 helper, default derived widths.
package wsc_pkg;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_DATA_W  = 256;
  localparam int DEF_BANKS   = 2;
  localparam int DEF_STRIDE  = 8;
  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_SLICE_W = DEF_DATA_W / DEF_BANKS;
  localparam int DEF_ROW_W   = DEF_SLICE_W * DEF_STRIDE;
  localparam int DEF_PH_W    = clog2(DEF_STRIDE);
  localparam int DEF_OADDR_W = DEF_ADDR_W + DEF_PH_W;

endpackage

// File: rtl/write_scatter_engine_if.sv
// Word-in / row-write-out bundle of the scatter engine.
// Optional out_par present when WSC_PARITY_EN is defined.
interface write_scatter_engine_if #(
  parameter int DATA_W = 256,
  parameter int BANKS  = 2,
  parameter int STRIDE = 8,
  parameter int ADDR_W = 7
);
  import wsc_pkg::*;

  localparam int SLICE_W = DATA_W / BANKS;
  localparam int ROW_W   = SLICE_W * STRIDE;
  localparam int PH_W    = clog2(STRIDE);
  localparam int BANK_W  = clog2(BANKS);
  localparam int OADDR_W = ADDR_W + PH_W;

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [ADDR_W-1:0]  in_addr;
  logic [PH_W-1:0]    in_phase;
  logic               out_valid;
  logic               out_ready;
  logic [BANK_W-1:0]  out_bank;
  logic [OADDR_W-1:0] out_addr;
  logic [ROW_W-1:0]   out_data;
  logic [ROW_W-1:0]   out_mask;
  logic               out_last;
  logic               busy;
`ifdef WSC_PARITY_EN
  logic               out_par;
`endif

  modport slave (
    input  in_valid, in_data, in_addr, in_phase, out_ready,
    output in_ready, out_valid, out_bank, out_addr,
    output out_data, out_mask, out_last, busy
`ifdef WSC_PARITY_EN
    , output out_par
`endif
  );

  modport master (
    output in_valid, in_data, in_addr, in_phase, out_ready,
    input  in_ready, out_valid, out_bank, out_addr,
    input  out_data, out_mask, out_last, busy
`ifdef WSC_PARITY_EN
    , input out_par
`endif
  );

endinterface

// File: rtl/wsc_slice_scatter.sv
// Spreads one slice onto a row at a fixed stride.
// Slice bit k lands on row bit k*STRIDE+phase; mask marks those bits.
module wsc_slice_scatter #(
  parameter int SLICE_W = 128,
  parameter int STRIDE  = 8,
  parameter int PH_W    = 3
) (
  input  logic [SLICE_W-1:0]        slice_i,
  input  logic [PH_W-1:0]           phase_i,
  output logic [SLICE_W*STRIDE-1:0] row_o,
  output logic [SLICE_W*STRIDE-1:0] mask_o
);

  for (genvar k = 0; k < SLICE_W; k++) begin : g_grp
    assign row_o[k*STRIDE +: STRIDE] =
      {{(STRIDE-1){1'b0}}, slice_i[k]} << phase_i;
    assign mask_o[k*STRIDE +: STRIDE] =
      {{(STRIDE-1){1'b0}}, 1'b1} << phase_i;
  end

endmodule

// File: rtl/write_scatter_engine.sv
// Captures a word, then issues one masked row write per bank.
// Build option: WSC_PARITY_EN adds out_par (XOR of current slice).
module write_scatter_engine
  import wsc_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int BANKS  = 2,
  parameter int STRIDE = 8,
  parameter int ADDR_W = 7
) (
  input logic                  clk,
  input logic                  rst,
  write_scatter_engine_if.slave bus
);

  localparam int SLICE_W = DATA_W / BANKS;
  localparam int ROW_W   = SLICE_W * STRIDE;
  localparam int PH_W    = clog2(STRIDE);
  localparam int BANK_W  = clog2(BANKS);

  logic [0:0]        state_q, state_d;
  logic [BANK_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PH_W-1:0]   phase_q, phase_d;

  logic               issue;
  logic               accept;
  logic               beat_done;
  logic               last_beat;
  logic [SLICE_W-1:0] slc [BANKS];
  logic [SLICE_W-1:0] cur_slice;
  logic [ROW_W-1:0]   row;
  logic [ROW_W-1:0]   mask;

  assign issue     = (state_q == S_ISSUE);
  assign accept    = !issue && bus.in_valid;
  assign beat_done = issue && bus.out_ready;
  assign last_beat = (cnt_q == BANK_W'(BANKS-1));

  for (genvar b = 0; b < BANKS; b++) begin : g_slc
    assign slc[b] = data_q[b*SLICE_W +: SLICE_W];
  end

  assign cur_slice = slc[cnt_q];

  wsc_slice_scatter #(
    .SLICE_W (SLICE_W),
    .STRIDE  (STRIDE),
    .PH_W    (PH_W)
  ) u_scatter (
    .slice_i (cur_slice),
    .phase_i (phase_q),
    .row_o   (row),
    .mask_o  (mask)
  );

  // Next state: capture in IDLE, step bank counter per accepted beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    unique case (1'b1)
      accept: begin
        data_d  = bus.in_data;
        addr_d  = bus.in_addr;
        phase_d = bus.in_phase;
        cnt_d   = '0;
        state_d = S_ISSUE;
      end
      beat_done && last_beat: begin
        state_d = S_IDLE;
      end
      beat_done && !last_beat: begin
        cnt_d = cnt_q + BANK_W'(1);
      end
      default: begin
      end
    endcase
  end

  // State and capture registers; reset abandons any pending beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  assign bus.in_ready  = !issue;
  assign bus.busy      = issue;
  assign bus.out_valid = issue;
  assign bus.out_bank  = cnt_q;
  assign bus.out_addr  = {addr_q, {PH_W{1'b0}}};
  assign bus.out_data  = issue ? row  : '0;
  assign bus.out_mask  = issue ? mask : '0;
  assign bus.out_last  = issue && last_beat;
`ifdef WSC_PARITY_EN
  assign bus.out_par   = issue && (^cur_slice);
`endif

endmodule

// File: tb/tb_write_scatter_engine.sv
// Directed bench for write_scatter_engine.
// Hand-computed vectors; parity steps run when WSC_PARITY_EN is defined.
module tb_write_scatter_engine;

  localparam int DATA_W = 256;
  localparam int BANKS  = 2;
  localparam int STRIDE = 8;
  localparam int ADDR_W = 7;

  localparam logic [1023:0] M_PH0 = {128{8'h01}};
  localparam logic [1023:0] M_PH1 = {128{8'h02}};
  localparam logic [1023:0] M_PH3 = {128{8'h08}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  write_scatter_engine_if #(
    .DATA_W (DATA_W),
    .BANKS  (BANKS),
    .STRIDE (STRIDE),
    .ADDR_W (ADDR_W)
  ) bus ();

  write_scatter_engine #(
    .DATA_W (DATA_W),
    .BANKS  (BANKS),
    .STRIDE (STRIDE),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag,
                      input logic [1023:0] obs,
                      input logic [1023:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed ones=%0d lo=%0h expected ones=%0d lo=%0h",
             tag, $countones(obs), obs[63:0],
             $countones(exp), exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_addr   = '0;
    bus.in_phase  = '0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.out_valid), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_last", 64'(bus.out_last), 0);
    chk("rst_bank", 64'(bus.out_bank), 0);
    chk("rst_addr", 64'(bus.out_addr), 0);
    chkw("rst_data", bus.out_data, '0);
    chkw("rst_mask", bus.out_mask, '0);
`ifdef WSC_PARITY_EN
    chk("rst_par", 64'(bus.out_par), 0);
`endif
    rst = 1'b0;
    step();
    chk("rel_in_ready", 64'(bus.in_ready), 1);

    // slice0 all ones, slice1 zero, addr 5, phase 0
    bus.in_data   = {128'h0, {128{1'b1}}};
    bus.in_addr   = 7'd5;
    bus.in_phase  = 3'd0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t2_b0_valid", 64'(bus.out_valid), 1);
    chk("t2_b0_bank", 64'(bus.out_bank), 0);
    chk("t2_b0_addr", 64'(bus.out_addr), 40);
    chkw("t2_b0_data", bus.out_data, M_PH0);
    chkw("t2_b0_mask", bus.out_mask, M_PH0);
    chk("t2_b0_last", 64'(bus.out_last), 0);
    chk("t2_b0_busy", 64'(bus.busy), 1);
    chk("t2_b0_in_ready", 64'(bus.in_ready), 0);
    step();
    chk("t2_b1_valid", 64'(bus.out_valid), 1);
    chk("t2_b1_bank", 64'(bus.out_bank), 1);
    chk("t2_b1_addr", 64'(bus.out_addr), 40);
    chkw("t2_b1_data", bus.out_data, '0);
    chkw("t2_b1_mask", bus.out_mask, M_PH0);
    chk("t2_b1_last", 64'(bus.out_last), 1);
    step();
    chk("t2_idle_valid", 64'(bus.out_valid), 0);
    chk("t2_idle_in_ready", 64'(bus.in_ready), 1);
    chk("t2_idle_busy", 64'(bus.busy), 0);

    // bit0 and bit128 set, phase 3
    bus.in_data  = (256'h1 << 128) | 256'h1;
    bus.in_addr  = 7'd1;
    bus.in_phase = 3'd3;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t3_b0_bank", 64'(bus.out_bank), 0);
    chk("t3_b0_addr", 64'(bus.out_addr), 8);
    chkw("t3_b0_data", bus.out_data, 1024'h8);
    chkw("t3_b0_mask", bus.out_mask, M_PH3);
    step();
    chk("t3_b1_bank", 64'(bus.out_bank), 1);
    chkw("t3_b1_data", bus.out_data, 1024'h8);
    chkw("t3_b1_mask", bus.out_mask, M_PH3);
    chk("t3_b1_last", 64'(bus.out_last), 1);
    step();
    chk("t3_idle_valid", 64'(bus.out_valid), 0);

    // backpressure on beat0; max address, phase 1
    bus.out_ready = 1'b0;
    bus.in_data   = 256'hA5;
    bus.in_addr   = 7'd127;
    bus.in_phase  = 3'd1;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 64'(bus.out_valid), 1);
      chk("t4_hold_bank", 64'(bus.out_bank), 0);
      chk("t4_hold_addr", 64'(bus.out_addr), 1016);
      chkw("t4_hold_data", bus.out_data,
           1024'h0200020000020002);
      chkw("t4_hold_mask", bus.out_mask, M_PH1);
      chk("t4_hold_last", 64'(bus.out_last), 0);
      chk("t4_hold_in_ready", 64'(bus.in_ready), 0);
      step();
    end
    chk("t4_still_b0", 64'(bus.out_bank), 0);
    chk("t4_still_valid", 64'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    step();
    chk("t4_b1_bank", 64'(bus.out_bank), 1);
    chkw("t4_b1_data", bus.out_data, '0);
    chk("t4_b1_last", 64'(bus.out_last), 1);
    chk("t4_b1_addr", 64'(bus.out_addr), 1016);
    step();
    chk("t4_idle_valid", 64'(bus.out_valid), 0);

    // back-to-back words with in_valid held, then reset mid-beat
    bus.in_data  = (256'h2 << 128) | 256'h1;
    bus.in_addr  = 7'd2;
    bus.in_phase = 3'd0;
    bus.in_valid = 1'b1;
    step();
    bus.in_data = (256'h8 << 128) | 256'h4;
    bus.in_addr = 7'd3;
    chk("t5_a0_bank", 64'(bus.out_bank), 0);
    chk("t5_a0_addr", 64'(bus.out_addr), 16);
    chkw("t5_a0_data", bus.out_data, 1024'h1);
    chk("t5_a0_in_ready", 64'(bus.in_ready), 0);
    step();
    chk("t5_a1_bank", 64'(bus.out_bank), 1);
    chkw("t5_a1_data", bus.out_data, 1024'h100);
    chk("t5_a1_last", 64'(bus.out_last), 1);
    chk("t5_a1_in_ready", 64'(bus.in_ready), 0);
    step();
    chk("t5_gap_valid", 64'(bus.out_valid), 0);
    chk("t5_gap_in_ready", 64'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    chk("t5_b0_valid", 64'(bus.out_valid), 1);
    chk("t5_b0_bank", 64'(bus.out_bank), 0);
    chk("t5_b0_addr", 64'(bus.out_addr), 24);
    chkw("t5_b0_data", bus.out_data, 1024'h10000);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(bus.out_valid), 0);
    chk("t5_rst_busy", 64'(bus.busy), 0);
    chkw("t5_rst_data", bus.out_data, '0);
    chk("t5_rst_in_ready", 64'(bus.in_ready), 1);
    step();
    rst = 1'b0;
    step();
    chk("t5_post_valid", 64'(bus.out_valid), 0);
    chk("t5_post_in_ready", 64'(bus.in_ready), 1);

`ifdef WSC_PARITY_EN
    // slice0 has three ones, slice1 has four
    bus.in_data  = (256'hF << 128) | 256'h7;
    bus.in_addr  = 7'd0;
    bus.in_phase = 3'd0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t6_par0", 64'(bus.out_par), 1);
    step();
    chk("t6_par1", 64'(bus.out_par), 0);
    step();
    chk("t6_par_idle", 64'(bus.out_par), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
